// File: rtl/pipe_skid_reg.sv
// Two-entry skid register that decouples upstream and downstream handshakes.
// Every output is taken from registered state, so no input reaches an output combinationally.
module pipe_skid_reg #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               accept;
  logic               pop;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign in_ready  = in_ready_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    // Flush only resets occupancy; the data registers keep stale contents, hidden by out_valid=0.
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (!accept && pop) begin
            state_d = EMPTY;
          end else if (accept && pop) begin
            main_d = in_data;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Registered ready: computed from the state being entered, not the current one.
    in_ready_d = (state_d != TWO);

    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 32, payload width in bits (>=1)
- BUBBLE, {WIDTH{1'b0}}, value driven on out_data when no valid entry is held
- CNT_W, 16, stall counter width (>=2)
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  head payload, or BUBBLE when empty
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles
- occupancy  output  2  number of held words (0..2)
REQ-003 The single clock is clk; reset is asynchronous and active-low, named reset.

Function
REQ-004 Storage SHALL be two WIDTH registers, main (head) and skid, managed by FSM states EMPTY (0 held), ONE (main held), TWO (main+skid held).
REQ-005 Handshakes: accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-006 in_ready SHALL be a registered output, 1 exactly when state != TWO.
REQ-007 out_valid SHALL be 1 exactly when state != EMPTY; out_data = main when out_valid, else BUBBLE.
REQ-008 occupancy SHALL be 0/1/2 for EMPTY/ONE/TWO.
REQ-009 Transitions when flush=0:
- EMPTY: accept -> ONE, main<=in_data; else stay.
- ONE: accept&!pop -> TWO, skid<=in_data; !accept&pop -> EMPTY; accept&pop -> ONE, main<=in_data; else stay.
- TWO: pop -> ONE, main<=skid; else stay (no accept possible).
REQ-010 Latency: an accepted word SHALL appear on out_data/out_valid the cycle after acceptance when the block was EMPTY; throughput SHALL be one word per cycle with out_ready held 1.
REQ-011 Order SHALL be strictly FIFO; no word is lost or duplicated.
REQ-012 flush=1 SHALL force state to EMPTY at the next edge, overriding any simultaneous accept or pop; the word offered that cycle is dropped; in_ready is 1 the following cycle.
REQ-013 Data registers are not cleared by flush; out_data SHALL show BUBBLE because out_valid=0.
REQ-014 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-015 Inputs SHALL be sampled only on the rising edge of clk; out_data, out_valid, in_ready and occupancy SHALL depend on registered state only (no combinational in->out path).

Reset
REQ-016 While reset=0, asynchronously: state=EMPTY, main=skid=BUBBLE, in_ready=1, out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0.
REQ-017 Reset asserted mid-transfer SHALL discard all held words immediately; the first edge after reset release SHALL behave as EMPTY.

Verification
REQ-018 Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the next four cycles, in_ready always 1, stall_cnt=0.
REQ-019 Back-pressure: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, 0xC held off; raise out_ready -> 0xA, 0xB, 0xC emerge in order; stall_cnt equals cycles spent with out_valid=1, out_ready=0.
REQ-020 Flush collision: state TWO, flush=1 with in_valid=1 (0xD) and out_ready=1 -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1; 0xD never appears.
REQ-021 Saturation: CNT_W=2, out_valid=1 and out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3.
REQ-022 Async reset: state TWO, pulse reset=0 between clock edges -> outputs take reset values before the next edge; after release, push 0x5 -> out_data=0x5 one cycle later.
